// File: rtl/i_decode.sv
// i_decode: decode stage of the 5-stage DLX pipeline.
// Owns the 32x32 register file, splits instruction fields, resolves
// branches and jumps in ID, detects load-use and branch-operand hazards,
// and registers the ID/EX bundle consumed by the execute stage.
module i_decode #(
  parameter int NREGS    = 32,
  parameter int LINK_REG = 31
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [0:31] instr,
  input  logic [0:31] pc_plus_four,
  input  logic        wb_we,
  input  logic [0:4]  wb_rd,
  input  logic [0:31] wb_data,
  input  logic [0:4]  mem_rd,
  input  logic        mem_mem_read,
  output logic        reg_lock,
  output logic        jump_or_branch,
  output logic [0:31] target,
  output logic [0:31] ex_a,
  output logic [0:31] ex_b,
  output logic [0:31] ex_imm,
  output logic [0:4]  ex_rd,
  output logic        ex_we,
  output logic        ex_mem_read,
  output logic        ex_mem_write,
  output logic        ex_alu_src,
  output logic [0:5]  ex_alu_op,
  output logic [0:31] ex_pc_plus_four
);

  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQZ  = 6'h04;
  localparam logic [5:0] OP_BNEZ  = 6'h05;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_JR    = 6'h12;
  localparam logic [5:0] OP_JALR  = 6'h13;
  localparam logic [5:0] FUNC_ADD = 6'h20;
  localparam logic [4:0] LINK_RD  = 5'(LINK_REG);

  function automatic logic signed [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

  function automatic logic signed [31:0] sext26(input logic [25:0] v);
    return {{6{v[25]}}, v};
  endfunction

  // Instruction fields (bit 0 of instr is the MSB)
  logic [5:0]  op;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd_r;
  logic [5:0]  func;
  logic [15:0] imm16;
  logic [25:0] off26;

  assign op    = instr[0:5];
  assign rs1   = instr[6:10];
  assign rs2   = instr[11:15];
  assign rd_r  = instr[16:20];
  assign func  = instr[26:31];
  assign imm16 = instr[16:31];
  assign off26 = instr[6:31];

  // Instruction classes; anything unrecognised decodes as a non-writing op
  logic is_r, is_load, is_store, is_alui, is_br, is_j, is_jal, is_jr, is_jalr, is_zext;

  assign is_r     = (op == 6'h00) || (op == 6'h01);
  assign is_load  = (op == 6'h20) || (op == 6'h21) || (op == 6'h23) ||
                    (op == 6'h24) || (op == 6'h25);
  assign is_store = (op == 6'h28) || (op == 6'h29) || (op == 6'h2B);
  assign is_alui  = ((op >= 6'h08) && (op <= 6'h0F)) || ((op >= 6'h14) && (op <= 6'h1F));
  assign is_br    = (op == OP_BEQZ) || (op == OP_BNEZ);
  assign is_j     = (op == OP_J);
  assign is_jal   = (op == OP_JAL);
  assign is_jr    = (op == OP_JR);
  assign is_jalr  = (op == OP_JALR);
  assign is_zext  = (op >= OP_ANDI) && (op <= OP_XORI);

  // Register file; r0 is never written and always reads zero
  logic [31:0] regs [NREGS];

  // Writeback port into the register file, cleared on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wb_we && (wb_rd != 5'd0)) begin
      regs[wb_rd] <= wb_data;
    end
  end

  // Reads see a same-cycle writeback so WB->ID needs no extra stall
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;

  assign rs1_val = (rs1 == 5'd0) ? 32'd0 : (wb_we && (wb_rd == rs1)) ? wb_data : regs[rs1];
  assign rs2_val = (rs2 == 5'd0) ? 32'd0 : (wb_we && (wb_rd == rs2)) ? wb_data : regs[rs2];

  // Hazards: only sources the instruction really reads can cause a stall
  logic squash;
  logic uses_rs1, uses_rs2, load_use, br_hazard, taken, bubble;

  assign uses_rs1  = is_r | is_load | is_store | is_alui | is_br | is_jr | is_jalr;
  assign uses_rs2  = is_r | is_store;
  assign load_use  = ex_mem_read && (ex_rd != 5'd0) &&
                     ((uses_rs1 && (ex_rd == rs1)) || (uses_rs2 && (ex_rd == rs2)));
  assign br_hazard = (is_br | is_jr | is_jalr) && (rs1 != 5'd0) &&
                     ((ex_we && (ex_rd == rs1)) || (mem_mem_read && (mem_rd == rs1)));
  assign reg_lock  = rst_n & ~squash & (load_use | br_hazard);

  assign taken = ((op == OP_BEQZ) && (rs1_val == 32'd0)) ||
                 ((op == OP_BNEZ) && (rs1_val != 32'd0)) ||
                 is_j || is_jal || is_jr || is_jalr;
  assign jump_or_branch = rst_n & ~squash & ~reg_lock & taken;
  assign bubble = squash | reg_lock;

  logic signed [31:0] br_off;
  logic signed [31:0] jmp_off;

  assign br_off  = sext16(imm16);
  assign jmp_off = sext26(off26);

  // Redirect address; wraps modulo 2^32
  always_comb begin
    if (is_jr || is_jalr)     target = rs1_val;
    else if (is_j || is_jal)  target = pc_plus_four + jmp_off;
    else                      target = pc_plus_four + br_off;
  end

  // ---- stage p0: decoded ID/EX bundle (bubble when stalled or squashed) ----
  logic [31:0] a_p0, b_p0, imm_p0, pc4_p0;
  logic [4:0]  rd_p0;
  logic [5:0]  alu_op_p0;
  logic        we_p0, mr_p0, mw_p0, src_p0;

  // Build the next ID/EX bundle from the current instruction
  always_comb begin
    a_p0      = rs1_val;
    b_p0      = rs2_val;
    imm_p0    = is_zext ? {16'h0000, imm16} : br_off;
    pc4_p0    = pc_plus_four;
    mr_p0     = is_load;
    mw_p0     = is_store;
    src_p0    = is_load | is_store | is_alui;
    alu_op_p0 = is_r ? func : op;
    rd_p0     = 5'd0;
    if (is_r)                  rd_p0 = rd_r;
    else if (is_load | is_alui) rd_p0 = rs2;
    if (is_jal | is_jalr) begin
      a_p0      = pc_plus_four;
      b_p0      = 32'd0;
      alu_op_p0 = FUNC_ADD;
      rd_p0     = LINK_RD;
    end
    we_p0 = (rd_p0 != 5'd0);
    if (bubble) begin
      a_p0      = 32'd0;
      b_p0      = 32'd0;
      imm_p0    = 32'd0;
      pc4_p0    = 32'd0;
      rd_p0     = 5'd0;
      alu_op_p0 = 6'd0;
      we_p0     = 1'b0;
      mr_p0     = 1'b0;
      mw_p0     = 1'b0;
      src_p0    = 1'b0;
    end
  end

  // ---- stage p1: ID/EX register ----
  // Load the ID/EX bundle every cycle; reset produces a NOP
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_a            <= '0;
      ex_b            <= '0;
      ex_imm          <= '0;
      ex_pc_plus_four <= '0;
      ex_rd           <= '0;
      ex_alu_op       <= '0;
      ex_we           <= 1'b0;
      ex_mem_read     <= 1'b0;
      ex_mem_write    <= 1'b0;
      ex_alu_src      <= 1'b0;
    end else begin
      ex_a            <= a_p0;
      ex_b            <= b_p0;
      ex_imm          <= imm_p0;
      ex_pc_plus_four <= pc4_p0;
      ex_rd           <= rd_p0;
      ex_alu_op       <= alu_op_p0;
      ex_we           <= we_p0;
      ex_mem_read     <= mr_p0;
      ex_mem_write    <= mw_p0;
      ex_alu_src      <= src_p0;
    end
  end

  // Kill the instruction fetched behind a taken redirect (no delay slot)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) squash <= 1'b0;
    else        squash <= jump_or_branch;
  end

endmodule

// File: tb/tb_i_decode.sv
// tb_i_decode: directed stimulus for i_decode with a behavioural model
// compared every cycle plus hand-computed literal expectations.
module tb_i_decode;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [0:31] instr = '0;
  logic [0:31] pc_plus_four = '0;
  logic        wb_we = 1'b0;
  logic [0:4]  wb_rd = '0;
  logic [0:31] wb_data = '0;
  logic [0:4]  mem_rd = '0;
  logic        mem_mem_read = 1'b0;
  logic        reg_lock, jump_or_branch;
  logic [0:31] target, ex_a, ex_b, ex_imm, ex_pc_plus_four;
  logic [0:4]  ex_rd;
  logic        ex_we, ex_mem_read, ex_mem_write, ex_alu_src;
  logic [0:5]  ex_alu_op;

  i_decode dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .pc_plus_four(pc_plus_four),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .mem_rd(mem_rd), .mem_mem_read(mem_mem_read),
    .reg_lock(reg_lock), .jump_or_branch(jump_or_branch), .target(target),
    .ex_a(ex_a), .ex_b(ex_b), .ex_imm(ex_imm), .ex_rd(ex_rd), .ex_we(ex_we),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_alu_src(ex_alu_src),
    .ex_alu_op(ex_alu_op), .ex_pc_plus_four(ex_pc_plus_four)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [31:0] a, b, imm, pc4;
    logic [4:0]  rd;
    logic [5:0]  alu;
    logic        we, mr, mw, src;
  } bnd_t;

  localparam int K_R = 0, K_LD = 1, K_ST = 2, K_AI = 3, K_BR = 4, K_J = 5,
                 K_JAL = 6, K_JR = 7, K_JALR = 8, K_OTH = 9;

  function automatic int kind_of(input int op);
    if (op == 0 || op == 1)                     return K_R;
    if (op == 2)                                return K_J;
    if (op == 3)                                return K_JAL;
    if (op == 4 || op == 5)                     return K_BR;
    if (op == 18)                               return K_JR;
    if (op == 19)                               return K_JALR;
    if (op == 32 || op == 33 || op == 35 || op == 36 || op == 37) return K_LD;
    if (op == 40 || op == 41 || op == 43)       return K_ST;
    if ((op >= 8 && op <= 15) || (op >= 20 && op <= 31)) return K_AI;
    return K_OTH;
  endfunction

  logic [31:0] m_rf [32];
  bnd_t cur, nxt;
  bit   sq, lock, jb;
  logic [31:0] tgt;

  function automatic logic [31:0] rval(input logic [4:0] r);
    if (r == 5'd0) return 32'd0;
    if (wb_we && wb_rd == r) return wb_data;
    return m_rf[r];
  endfunction

  // single compare process: evaluate model and check DUT at negedge, commit at posedge
  initial begin
    logic [31:0] w, v1, v2, simm, joff;
    logic [4:0]  s1, s2, rr;
    logic [5:0]  op, fn;
    logic [15:0] i16;
    logic [25:0] o26;
    int k;
    bit uses1, uses2, tk;
    cur = '0; nxt = '0; sq = 0; lock = 0; jb = 0; tgt = '0;
    for (int i = 0; i < 32; i++) m_rf[i] = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        for (int i = 0; i < 32; i++) m_rf[i] = '0;
        cur = '0; nxt = '0; sq = 0; lock = 0; jb = 0;
      end else begin
        w   = instr;
        op  = 6'(w >> 26);
        s1  = 5'(w >> 21);
        s2  = 5'(w >> 16);
        rr  = 5'(w >> 11);
        fn  = 6'(w);
        i16 = 16'(w);
        o26 = 26'(w);
        simm = (i16 >= 16'h8000) ? 32'(i16) - 32'h0001_0000 : 32'(i16);
        joff = (o26 >= 26'h200_0000) ? 32'(o26) - 32'h0400_0000 : 32'(o26);
        k  = kind_of(int'(op));
        v1 = rval(s1);
        v2 = rval(s2);
        uses1 = (k == K_R || k == K_LD || k == K_ST || k == K_AI || k == K_BR || k == K_JR || k == K_JALR);
        uses2 = (k == K_R || k == K_ST);
        lock = 0;
        if (cur.mr && cur.rd != 5'd0 && ((uses1 && cur.rd == s1) || (uses2 && cur.rd == s2))) lock = 1;
        if ((k == K_BR || k == K_JR || k == K_JALR) && s1 != 5'd0 &&
            ((cur.we && cur.rd == s1) || (mem_mem_read && mem_rd == s1))) lock = 1;
        if (sq) lock = 0;
        tk = (k == K_J || k == K_JAL || k == K_JR || k == K_JALR) ||
             (op == 6'd4 && v1 == 32'd0) || (op == 6'd5 && v1 != 32'd0);
        jb = tk && !lock && !sq;
        if (k == K_JR || k == K_JALR)    tgt = v1;
        else if (k == K_J || k == K_JAL) tgt = pc_plus_four + joff;
        else                             tgt = pc_plus_four + simm;
        nxt = '0;
        if (!(sq || lock)) begin
          nxt.a   = v1;
          nxt.b   = v2;
          nxt.pc4 = pc_plus_four;
          nxt.imm = (op >= 6'd12 && op <= 6'd14) ? 32'(i16) : simm;
          nxt.mr  = (k == K_LD);
          nxt.mw  = (k == K_ST);
          nxt.src = (k == K_LD || k == K_ST || k == K_AI);
          nxt.alu = (k == K_R) ? fn : op;
          if (k == K_R) nxt.rd = rr;
          else if (k == K_LD || k == K_AI) nxt.rd = s2;
          if (k == K_JAL || k == K_JALR) begin
            nxt.a = pc_plus_four; nxt.b = 32'd0; nxt.alu = 6'h20; nxt.rd = 5'd31;
          end
          nxt.we = (nxt.rd != 5'd0);
        end
      end
      chk("m reg_lock", 32'(reg_lock), 32'(lock));
      chk("m jump_or_branch", 32'(jump_or_branch), 32'(jb));
      if (jb) chk("m target", target, tgt);
      chk("m ex_a", ex_a, cur.a);
      chk("m ex_b", ex_b, cur.b);
      chk("m ex_imm", ex_imm, cur.imm);
      chk("m ex_pc_plus_four", ex_pc_plus_four, cur.pc4);
      chk("m ex_rd", 32'(ex_rd), 32'(cur.rd));
      chk("m ex_alu_op", 32'(ex_alu_op), 32'(cur.alu));
      chk("m ex_we", 32'(ex_we), 32'(cur.we));
      chk("m ex_mem_read", 32'(ex_mem_read), 32'(cur.mr));
      chk("m ex_mem_write", 32'(ex_mem_write), 32'(cur.mw));
      chk("m ex_alu_src", 32'(ex_alu_src), 32'(cur.src));
      @(posedge clk);
      if (rst_n) begin
        if (wb_we && wb_rd != 5'd0) m_rf[wb_rd] = wb_data;
        cur = nxt;
        sq  = jb;
      end
    end
  end

  // ---------------- stimulus ----------------
  function automatic logic [31:0] rt(input logic [4:0] rd, input logic [4:0] a, input logic [4:0] b, input logic [5:0] fn);
    return {6'h00, a, b, rd, 5'h00, fn};
  endfunction
  function automatic logic [31:0] it(input logic [5:0] op, input logic [4:0] a, input logic [4:0] rd, input logic [15:0] imm);
    return {op, a, rd, imm};
  endfunction
  function automatic logic [31:0] jt(input logic [5:0] op, input logic [25:0] off);
    return {op, off};
  endfunction

  task automatic step(input logic r, input logic [31:0] i, input logic [31:0] p,
                      input logic we, input logic [4:0] wrd, input logic [31:0] wd,
                      input logic mmr, input logic [4:0] mrd);
    @(posedge clk);
    #2;
    rst_n = r; instr = i; pc_plus_four = p;
    wb_we = we; wb_rd = wrd; wb_data = wd;
    mem_mem_read = mmr; mem_rd = mrd;
    @(negedge clk);
  endtask

  task automatic go(input logic [31:0] i, input logic [31:0] p);
    step(1'b1, i, p, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
  endtask

  task automatic go_wb(input logic [31:0] i, input logic [31:0] p, input logic [4:0] r, input logic [31:0] d);
    step(1'b1, i, p, 1'b1, r, d, 1'b0, 5'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] add_r4;
    #1 rst_n = 1'b0;
    step(1'b0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    step(1'b0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    chk("reset ex_we", 32'(ex_we), 32'd0);
    chk("reset ex_a", ex_a, 32'd0);
    chk("reset reg_lock", 32'(reg_lock), 32'd0);
    chk("reset jump_or_branch", 32'(jump_or_branch), 32'd0);

    go_wb(32'd0, 32'h4, 5'd5, 32'h0000_00AA);
    go(rt(5'd3, 5'd5, 5'd0, 6'h20), 32'h8);
    go_wb(rt(5'd4, 5'd9, 5'd5, 6'h20), 32'hC, 5'd9, 32'h1234);
    chk("add ex_a", ex_a, 32'hAA);
    chk("add ex_b", ex_b, 32'h0);
    chk("add ex_rd", 32'(ex_rd), 32'd3);
    chk("add ex_we", 32'(ex_we), 32'd1);
    go_wb(32'd0, 32'h10, 5'd0, 32'hDEAD);
    chk("bypass ex_a", ex_a, 32'h1234);
    chk("bypass ex_b", ex_b, 32'hAA);
    go(rt(5'd10, 5'd0, 5'd0, 6'h20), 32'h14);
    go(it(6'h23, 5'd1, 5'd2, 16'h0), 32'h18);
    chk("r0 ex_a", ex_a, 32'h0);
    add_r4 = rt(5'd4, 5'd2, 5'd2, 6'h20);
    go(add_r4, 32'h1C);
    chk("loaduse reg_lock", 32'(reg_lock), 32'd1);
    chk("loaduse ex_mem_read", 32'(ex_mem_read), 32'd1);
    go(add_r4, 32'h1C);
    chk("loaduse release", 32'(reg_lock), 32'd0);
    chk("loaduse bubble rd", 32'(ex_rd), 32'd0);
    chk("loaduse bubble we", 32'(ex_we), 32'd0);
    go(32'd0, 32'h20);
    chk("loaduse issue rd", 32'(ex_rd), 32'd4);

    go(it(6'h04, 5'd0, 5'd0, 16'h0010), 32'h100);
    chk("beqz taken", 32'(jump_or_branch), 32'd1);
    chk("beqz target", target, 32'h110);
    go(jt(6'h02, 26'd8), 32'h104);
    chk("squash no redirect", 32'(jump_or_branch), 32'd0);
    chk("squash no lock", 32'(reg_lock), 32'd0);
    go(jt(6'h03, 26'h3FF_FFFC), 32'h8);
    chk("squash bubble we", 32'(ex_we), 32'd0);
    chk("jal taken", 32'(jump_or_branch), 32'd1);
    chk("jal target", target, 32'h4);
    go(32'd0, 32'hC);
    chk("jal ex_rd", 32'(ex_rd), 32'd31);
    chk("jal ex_a", ex_a, 32'h8);
    chk("jal ex_b", ex_b, 32'h0);
    chk("jal ex_alu_op", 32'(ex_alu_op), 32'h20);

    go(it(6'h08, 5'd0, 5'd6, 16'h0040), 32'h10);
    go(it(6'h12, 5'd6, 5'd0, 16'h0), 32'h14);
    chk("jr lock", 32'(reg_lock), 32'd1);
    chk("jr no redirect while locked", 32'(jump_or_branch), 32'd0);
    chk("addi ex_imm", ex_imm, 32'h40);
    go_wb(it(6'h12, 5'd6, 5'd0, 16'h0), 32'h14, 5'd6, 32'h40);
    chk("jr release", 32'(reg_lock), 32'd0);
    chk("jr target", target, 32'h40);
    go(32'd0, 32'h44);

    step(1'b1, it(6'h05, 5'd7, 5'd0, 16'h0020), 32'h200, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7);
    chk("bnez mem lock", 32'(reg_lock), 32'd1);
    step(1'b1, it(6'h05, 5'd7, 5'd0, 16'h0020), 32'h200, 1'b1, 5'd7, 32'd9, 1'b0, 5'd0);
    chk("bnez release", 32'(reg_lock), 32'd0);
    chk("bnez taken", 32'(jump_or_branch), 32'd1);
    chk("bnez target", target, 32'h220);
    go(32'd0, 32'h204);
    go(it(6'h05, 5'd0, 5'd0, 16'h0020), 32'h300);
    chk("bnez r0 not taken", 32'(jump_or_branch), 32'd0);
    go(it(6'h04, 5'd5, 5'd0, 16'h0020), 32'h304);
    chk("beqz r5 not taken", 32'(jump_or_branch), 32'd0);

    go(it(6'h0C, 5'd5, 5'd12, 16'h8000), 32'h308);
    go(it(6'h08, 5'd5, 5'd13, 16'h8000), 32'h30C);
    chk("andi zext", ex_imm, 32'h0000_8000);
    go(it(6'h2B, 5'd3, 5'd5, 16'h0004), 32'h310);
    chk("addi sext", ex_imm, 32'hFFFF_8000);
    go(rt(5'd14, 5'd5, 5'd5, 6'h20), 32'h314);
    chk("sw ex_mem_write", 32'(ex_mem_write), 32'd1);
    chk("sw ex_rd", 32'(ex_rd), 32'd0);
    chk("sw ex_we", 32'(ex_we), 32'd0);
    chk("sw ex_b", ex_b, 32'hAA);

    step(1'b0, it(6'h04, 5'd0, 5'd0, 16'h0010), 32'h400, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    chk("midrst jump_or_branch", 32'(jump_or_branch), 32'd0);
    chk("midrst ex_rd", 32'(ex_rd), 32'd0);
    chk("midrst ex_we", 32'(ex_we), 32'd0);
    chk("midrst ex_a", ex_a, 32'd0);
    go(rt(5'd15, 5'd5, 5'd0, 6'h20), 32'h404);
    go(32'd0, 32'h408);
    chk("post rst ex_rd", 32'(ex_rd), 32'd15);
    chk("post rst regfile", ex_a, 32'd0);
    go(32'd0, 32'h40C);
    go(32'd0, 32'h410);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/i_decode.md
Name: i_decode

Overview:
- Decode stage of the 5-stage DLX pipeline; consumes the instr and pc_plus_four registers produced by i_fetch.
- Holds the 32x32 register file, decodes fields, resolves branches/jumps, and drives target, jump_or_branch and reg_lock back to i_fetch.
- Detects load-use and branch-operand hazards and registers the ID/EX pipeline bundle for the execute stage.

Parameters:
- NREGS, 32, register count; r0 is hardwired to zero.
- LINK_REG, 31, destination register for JAL/JALR.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- instr  in  [0:31]  instruction from i_fetch.
- pc_plus_four  in  [0:31]  PC+4 of instr.
- wb_we  in  1  writeback enable.
- wb_rd  in  [0:4]  writeback register.
- wb_data  in  [0:31]  writeback data.
- mem_rd  in  [0:4]  destination of the instruction in MEM.
- mem_mem_read  in  1  instruction in MEM is a load.
- reg_lock  out  1  stall to i_fetch; combinational.
- jump_or_branch  out  1  redirect to i_fetch; combinational.
- target  out  [0:31]  redirect address; combinational.
- ex_a, ex_b  out  [0:31]  registered rs1/rs2 values.
- ex_imm  out  [0:31]  registered extended immediate.
- ex_rd  out  [0:4]  registered destination register.
- ex_we, ex_mem_read, ex_mem_write, ex_alu_src  out  1 each  registered controls.
- ex_alu_op  out  [0:5]  registered func (R-type) or opcode (I-type).
- ex_pc_plus_four  out  [0:31]  registered PC+4.

Behaviour:
- Fields (bit 0 = MSB):
  - op = [0:5], rs1 = [6:10], rs2 = [11:15].
  - R-type (op 0x00/0x01): rd = [16:20], func = [26:31].
  - I-type: rd = [11:15], imm16 = [16:31].
  - J-type: off26 = [6:31].
- Immediates:
  - Sign-extend for arithmetic, loads/stores and branches.
  - Zero-extend for ANDI/ORI/XORI (0x0C–0x0E).
- Register file:
  - Write on posedge when wb_we and wb_rd != 0.
  - Reads are combinational with write-through bypass: a same-cycle wb to rs returns wb_data.
  - r0 always reads 0.
  - Asynchronous reset clears all registers to 0.
- Branches and jumps, resolved in ID:
  - BEQZ (0x04) is taken if rs1 == 0; BNEZ (0x05) is taken if rs1 != 0.
  - Branch target = pc_plus_four + sext(imm16).
  - J (0x02) and JAL (0x03) target = pc_plus_four + sext(off26).
  - JR (0x12) and JALR (0x13) target = rs1 value.
  - JAL/JALR write LINK_REG with pc_plus_four: ex_a = pc_plus_four, ex_alu_op = ADD, ex_b = 0.
  - jump_or_branch = taken & ~reg_lock & ~squash & rst_n. Adder wrap is modulo 2^32.
- Squash (no delay slot):
  - When jump_or_branch = 1, the squash flop sets on the next posedge.
  - While squash = 1, the instr present is treated as NOP: no redirect, no stall, bubble into ID/EX.
  - squash clears on the following posedge.
- Hazards, reg_lock = 1:
  - Load-use: ex_mem_read and ex_rd != 0 and ex_rd equals a source actually used by instr.
  - Branch/JR/JALR operand: (ex_we and ex_rd == rs1 != 0), or (mem_mem_read and mem_rd == rs1 != 0).
  - While locked, ID/EX loads a bubble (all ex_* controls 0, ex_rd 0). i_fetch holds instr, so decode repeats the next cycle.
- ID/EX register:
  - Updates every posedge with the decoded bundle or a bubble.
  - Stores leave ex_rd = 0 and ex_we = 0.
  - Reset value of every ex_* output is 0 (NOP).
- Reset:
  - rst_n low forces all ex_* outputs, squash and the regfile to 0, and holds reg_lock = 0 and jump_or_branch = 0.
  - rst_n may be asserted mid-operation; the first post-reset cycle decodes normally.
- Latency: 1 cycle from instr to ex_* outputs; redirect and stall are same-cycle combinational.

Test Plan:
- Write r5 = 0x0000_00AA via wb, then ADD r3, r5, r0 -> the next cycle gives ex_a = 0xAA, ex_b = 0, ex_rd = 3, ex_we = 1. Same-cycle wb to r5 bypasses. A write to r0 is ignored.
- LW r2, 0(r1) followed by ADD r4, r2, r2 -> reg_lock = 1 for exactly one cycle and a bubble appears on ex_*. ADD issues on the next cycle.
- BEQZ r0, imm 0x0010 with pc_plus_four 0x100 -> jump_or_branch = 1 and target = 0x110. The next instr is squashed (bubble) and there is no redirect that cycle.
- JAL off26 = 0x3FFFFFC (-4) with pc_plus_four 0x8 -> target = 0x4, ex_rd = 31, ex_a = 0x8.
- ADDI r6 followed by JR r6 -> one stall cycle, then target = the r6 value. BNEZ on a register loaded by the instruction in MEM stalls one cycle.
- Assert rst_n low mid-stream -> all ex_* = 0 and jump_or_branch = 0 immediately, and the regfile reads 0 after release.
